// File: rtl/sysid_check_ctrl.sv
// Boot-time system-ID checker: reads the sysid slave's ID and timestamp words over Avalon-MM,
// compares them with the build constants and retries reads that time out.
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1720111226,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  MaxRetries  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StIdle,
    StIdReq,
    StIdWait,
    StTsReq,
    StTsWait,
    StCompare,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic        avm_address_q, avm_address_d;
  logic        avm_read_q, avm_read_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        pass_q, pass_d;
  logic        timeout_err_q, timeout_err_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [3:0]  rcnt_q, rcnt_d;

  logic enter_run;
  logic abort;
  logic timeout_hit;

  always_comb begin
    state_d       = state_q;
    avm_address_d = avm_address_q;
    avm_read_d    = avm_read_q;
    busy_d        = busy_q;
    done_d        = done_q;
    id_ok_d       = id_ok_q;
    ts_ok_d       = ts_ok_q;
    pass_d        = pass_q;
    timeout_err_d = timeout_err_q;
    id_value_d    = id_value_q;
    ts_value_d    = ts_value_q;
    tcnt_d        = tcnt_q;
    rcnt_d        = rcnt_q;
    enter_run     = 1'b0;
    abort         = 1'b0;
    // The current cycle is the last one the transaction is allowed to use.
    timeout_hit   = (tcnt_q == TimeoutLast);

    unique case (state_q)
      StIdle: enter_run = 1'b1;
      StIdReq, StTsReq: begin
        tcnt_d = tcnt_q + 16'd1;
        if (avm_read_q && !avm_waitrequest) begin
          avm_read_d = 1'b0;
          state_d    = (state_q == StIdReq) ? StIdWait : StTsWait;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end else begin
          // Re-raises the request after the idle cycle that follows a retry.
          avm_read_d = 1'b1;
        end
      end
      StIdWait: begin
        tcnt_d = tcnt_q + 16'd1;
        if (avm_readdatavalid) begin
          id_value_d    = avm_readdata;
          state_d       = StTsReq;
          avm_read_d    = 1'b1;
          avm_address_d = 1'b1;
          tcnt_d        = '0;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end
      StTsWait: begin
        tcnt_d = tcnt_q + 16'd1;
        if (avm_readdatavalid) begin
          ts_value_d = avm_readdata;
          state_d    = StCompare;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end
      StCompare: begin
        id_ok_d = (id_value_q == EXPECTED_ID);
        ts_ok_d = (ts_value_q == EXPECTED_TS);
        pass_d  = id_ok_d & (ts_ok_d | !CHECK_TS) & !timeout_err_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StDone;
      end
      StDone: enter_run = start;
      default: state_d = StIdle;
    endcase

    if (abort) begin
      avm_read_d = 1'b0;
      if (rcnt_q < MaxRetries) begin
        rcnt_d        = rcnt_q + 4'd1;
        avm_address_d = 1'b0;
        tcnt_d        = '0;
        state_d       = StIdReq;
      end else begin
        timeout_err_d = 1'b1;
        busy_d        = 1'b0;
        done_d        = 1'b1;
        state_d       = StDone;
      end
    end

    if (enter_run) begin
      state_d       = StIdReq;
      avm_read_d    = 1'b1;
      avm_address_d = 1'b0;
      busy_d        = 1'b1;
      done_d        = 1'b0;
      id_ok_d       = 1'b0;
      ts_ok_d       = 1'b0;
      pass_d        = 1'b0;
      timeout_err_d = 1'b0;
      rcnt_d        = '0;
      tcnt_d        = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      avm_address_q <= 1'b0;
      avm_read_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      pass_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      id_value_q    <= '0;
      ts_value_q    <= '0;
      tcnt_q        <= '0;
      rcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      avm_address_q <= avm_address_d;
      avm_read_q    <= avm_read_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      id_ok_q       <= id_ok_d;
      ts_ok_q       <= ts_ok_d;
      pass_q        <= pass_d;
      timeout_err_q <= timeout_err_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
      tcnt_q        <= tcnt_d;
      rcnt_q        <= rcnt_d;
    end
  end

  assign avm_address = avm_address_q;
  assign avm_read    = avm_read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign pass        = pass_q;
  assign timeout_err = timeout_err_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule
